// File: rtl/node_pkg.sv
// Shared opcode and FSM encodings for the sensor-node sequencer.
// Kept parameter-free so every file can import it.
package node_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_RD_SENSOR = 3'd1;
  localparam logic [2:0] OP_RD_RADIO  = 3'd2;
  localparam logic [2:0] OP_WR_RADIO  = 3'd3;
  localparam logic [2:0] OP_WR_MEM    = 3'd4;
  localparam logic [2:0] OP_RD_MEM    = 3'd5;
  localparam logic [2:0] OP_SCAN      = 3'd6;
  localparam logic [2:0] OP_ILL       = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_SENSE, S_RX_WAIT, S_TX, S_MEM_WR, S_MEM_RD, S_MEM_CAP, S_SCAN, S_DONE
  } state_e;

  // First state entered when an opcode is accepted; NOP never leaves IDLE.
  function automatic state_e op_state(input logic [2:0] op);
    case (op)
      OP_RD_SENSOR: return S_SENSE;
      OP_RD_RADIO:  return S_RX_WAIT;
      OP_WR_RADIO:  return S_TX;
      OP_WR_MEM:    return S_MEM_WR;
      OP_RD_MEM:    return S_MEM_RD;
      OP_SCAN:      return S_SCAN;
      OP_ILL:       return S_DONE;
      default:      return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/node_ram_sp.sv
// Single-port synchronous RAM, one-cycle read latency, no reset on contents.
module node_ram_sp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/node_seq_mc.sv
// Multi-channel sensor-node instruction sequencer: executes one 3-bit opcode
// at a time against ACC, sensor channels, local RAM and a radio TX/RX port.
module node_seq_mc
  import node_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 4,
  parameter int MEM_DEPTH = 16,
  parameter int RADIO_TO  = 64,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW       = $clog2(MEM_DEPTH),
  localparam int TW       = $clog2(RADIO_TO + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     inst_valid,
  input  logic [2:0]               inst,
  input  logic [CW-1:0]            ch_sel,
  input  logic [AW-1:0]            addr,
  output logic                     inst_ready,
  output logic                     busy,
  input  logic [NUM_CH*DATA_W-1:0] sensor_in,
  output logic                     tx_valid,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_ready,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_data,
  output logic                     done,
  output logic [DATA_W-1:0]        result,
  output logic                     error
);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [AW-1:0] addr;
  } cmd_t;

  state_e            state, state_nx;
  cmd_t              cmd;
  logic [DATA_W-1:0] acc;
  logic [TW-1:0]     cnt;
  logic [CW-1:0]     idx;
  logic              err_r;
  logic              accept, timeout, last_scan;

  // Channel table padded to a power of two so out-of-range selects read as invalid.
  logic [2**CW-1:0][DATA_W-1:0] sens;
  logic [2**CW-1:0]             ch_ok;

  for (genvar i = 0; i < 2**CW; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      assign sens[i]  = sensor_in[i*DATA_W +: DATA_W];
      assign ch_ok[i] = 1'b1;
    end else begin : g_off
      assign sens[i]  = '0;
      assign ch_ok[i] = 1'b0;
    end
  end

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  assign ram_we   = (state == S_MEM_WR) || (state == S_SCAN);
  assign ram_addr = (state == S_SCAN) ? cmd.addr + AW'(idx) : cmd.addr;
  assign ram_din  = (state == S_SCAN) ? sens[idx] : acc;

  node_ram_sp #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign inst_ready = enable && (state == S_IDLE) && !rst;
  assign busy       = (state != S_IDLE);
  assign tx_valid   = (state == S_TX);
  assign tx_data    = tx_valid ? acc : '0;
  assign accept     = inst_valid && inst_ready;
  assign timeout    = (cnt == TW'(RADIO_TO - 1));
  assign last_scan  = (idx == CW'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:                       if (accept) state_nx = op_state(inst);
      S_SENSE, S_MEM_WR, S_MEM_CAP: state_nx = S_DONE;
      S_MEM_RD:                     state_nx = S_MEM_CAP;
      S_RX_WAIT:                    if (rx_valid || timeout) state_nx = S_DONE;
      S_TX:                         if (tx_ready || timeout) state_nx = S_DONE;
      S_SCAN:                       if (last_scan) state_nx = S_DONE;
      default:                      state_nx = S_IDLE;
    endcase
  end

  // A handshake on the last window cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd    <= '0;
      acc    <= '0;
      cnt    <= '0;
      idx    <= '0;
      err_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          cmd   <= '{ch: ch_sel, addr: addr};
          err_r <= (inst == OP_ILL);
          cnt   <= '0;
          idx   <= '0;
        end
        S_SENSE: begin
          if (ch_ok[cmd.ch]) acc   <= sens[cmd.ch];
          else               err_r <= 1'b1;
        end
        S_RX_WAIT: begin
          if (rx_valid)     acc   <= rx_data;
          else if (timeout) err_r <= 1'b1;
          else              cnt   <= cnt + 1'b1;
        end
        S_TX: if (!tx_ready) begin
          if (timeout) err_r <= 1'b1;
          else         cnt   <= cnt + 1'b1;
        end
        S_MEM_CAP: acc <= ram_dout;
        S_SCAN: begin
          idx <= idx + 1'b1;
          if (last_scan) acc <= sens[idx];
        end
        S_DONE: begin
          done   <= 1'b1;
          result <= acc;
          error  <= err_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_seq_mc.sv
// Randomised bench for node_seq_mc against a transaction-level model of ACC/RAM/latencies.
module tb_node_seq_mc;
  localparam int DW = 8, NCH = 4, DEPTH = 16, RTO = 64, CW = 2, AW = 4;

  logic clk = 0, rst = 1, enable = 0, inst_valid = 0;
  logic [2:0] inst = 0;
  logic [CW-1:0] ch_sel = 0;
  logic [AW-1:0] addr = 0;
  logic inst_ready, busy, tx_valid, done, error;
  logic [NCH*DW-1:0] sensor_in = 0;
  logic [DW-1:0] tx_data, result;
  logic tx_ready = 0, rx_valid = 0;
  logic [DW-1:0] rx_data = 0;

  node_seq_mc #(.DATA_W(DW), .NUM_CH(NCH), .MEM_DEPTH(DEPTH), .RADIO_TO(RTO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .inst_valid(inst_valid), .inst(inst),
    .ch_sel(ch_sel), .addr(addr), .inst_ready(inst_ready), .busy(busy),
    .sensor_in(sensor_in), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .result(result), .error(error)
  );

  // Three-channel build for the out-of-range channel select
  logic iv3 = 0, ir3, bz3, txv3, dn3, er3;
  logic [2:0] in3 = 0;
  logic [1:0] cs3 = 0;
  logic [AW-1:0] ad3 = 0;
  logic [3*DW-1:0] sens3 = 24'h302010;
  logic [DW-1:0] txd3, res3;

  node_seq_mc #(.DATA_W(DW), .NUM_CH(3), .MEM_DEPTH(DEPTH), .RADIO_TO(RTO)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .inst_valid(iv3), .inst(in3),
    .ch_sel(cs3), .addr(ad3), .inst_ready(ir3), .busy(bz3),
    .sensor_in(sens3), .tx_valid(txv3), .tx_data(txd3), .tx_ready(1'b0),
    .rx_valid(1'b0), .rx_data(8'h00), .done(dn3), .result(res3), .error(er3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: ACC, RAM image and the expected window of the instruction in flight.
  logic [DW-1:0] m_acc = 0, m_last_res = 0;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_wr [DEPTH];
  bit            cur_v = 0, cur_err = 0;
  int            cur_t = 0, cur_done = 0, cur_txend = 0;
  logic [DW-1:0] cur_res = 0, cur_txd = 0;
  bit            eb, et;

  always @(negedge clk) if (!rst) begin
    eb = cur_v && cyc >= cur_t && cyc < cur_done;
    et = cur_v && cyc >= cur_t && cyc < cur_txend;
    check("busy", busy, eb);
    check("inst_ready", inst_ready, enable && !eb);
    check("tx_valid", tx_valid, et);
    if (et) check("tx_data", tx_data, cur_txd);
    if (cur_v && cyc == cur_done) begin
      check("done", done, 1);
      check("result", result, cur_res);
      check("error", error, cur_err);
      m_last_res = cur_res;
    end else begin
      check("done_idle", done, 0);
      check("result_hold", result, m_last_res);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] op, input int ch, input int a, input int d,
                        input logic [DW-1:0] rxd, input bit rnd, input bit drop_en);
    int n, t, len, j, txend;
    logic [DW-1:0] sv [NCH];
    logic [DW-1:0] res;
    bit err;
    n = 0;
    while (!inst_ready && n < 200) begin step(); n++; end
    if (!inst_ready) begin
      tests++; fails++;
      $display("FAIL ready_wait: inst_ready still 0 after %0d cycles", n);
      return;
    end
    for (int k = 0; k < NCH; k++) sv[k] = rnd ? DW'($urandom) : sensor_in[k*DW +: DW];
    inst_valid = 1; inst = op; ch_sel = CW'(ch); addr = AW'(a);
    t = cyc + 1;
    res = m_acc; err = 0; len = 0; txend = 0;
    j = (d > RTO) ? RTO : d;
    case (op)
      3'd1: begin len = 2; if (ch < NCH) res = sensor_in[ch*DW +: DW]; else err = 1; end
      3'd2: begin len = j + 1; if (d <= RTO) res = rxd; else err = 1; end
      3'd3: begin len = j + 1; txend = t + j; err = (d > RTO); end
      3'd4: begin len = 2; m_mem[a] = m_acc; m_wr[a] = 1; end
      3'd5: begin len = 3; res = m_mem[a]; end
      3'd6: begin
        len = NCH + 1;
        for (int k = 0; k < NCH; k++) begin m_mem[(a + k) % DEPTH] = sv[k]; m_wr[(a + k) % DEPTH] = 1; end
        res = sv[NCH-1];
      end
      3'd7: begin len = 1; err = 1; end
      default: len = 0;
    endcase
    cur_txd = m_acc; m_acc = res;
    cur_v = (len > 0); cur_t = t; cur_done = t + len; cur_txend = txend;
    cur_res = res; cur_err = err;
    if (op != 3'd2 && op != 3'd3) begin rx_valid = 1; tx_ready = 1; rx_data = DW'($urandom); end
    step();
    inst_valid = 0; inst = 3'($urandom); ch_sel = CW'($urandom); addr = AW'($urandom);
    if (drop_en) enable = 0;
    for (int k = 0; cyc <= t + len; k++) begin
      if (op == 3'd6 && rnd && k < NCH) begin
        sensor_in = $urandom;
        sensor_in[k*DW +: DW] = sv[k];
      end
      if ((op == 3'd2 || op == 3'd3) && d <= RTO && k == d - 1) begin
        if (op == 3'd2) begin rx_valid = 1; rx_data = rxd; end
        else tx_ready = 1;
      end else if (op == 3'd2) begin
        rx_valid = 0; rx_data = DW'($urandom); tx_ready = 1'($urandom);
      end else if (op == 3'd3) begin
        tx_ready = 0; rx_valid = 1'($urandom);
      end
      step();
    end
    rx_valid = 0; tx_ready = 0; enable = 1;
  endtask

  task automatic run3(input logic [1:0] ch);
    int n;
    n = 0;
    while (!ir3 && n < 20) begin step(); n++; end
    iv3 = 1; in3 = 3'd1; cs3 = ch;
    step();
    iv3 = 0; cs3 = 2'($urandom);
    n = 0;
    while (!dn3 && n < 10) begin step(); n++; end
    if (!dn3) begin
      tests++; fails++;
      $display("FAIL dut3_done: no done pulse within %0d cycles", n);
    end
    step();
  endtask

  initial begin
    int t;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_wr[i] = 0; end
    enable = 1;
    repeat (3) step();
    check("rst_inst_ready", inst_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_error", error, 0);
    rst = 0;
    step();

    run3(2'd1);
    check("ch3_ok_res", res3, 8'h20);  check("ch3_ok_err", er3, 0);
    run3(2'd3);
    check("ch3_bad_res", res3, 8'h20); check("ch3_bad_err", er3, 1);
    run3(2'd2);
    check("ch3_hi_res", res3, 8'h30);  check("ch3_hi_err", er3, 0);

    sensor_in = 32'h40302010;
    run_op(3'd1, 2, 0, 0, 8'h00, 0, 0);
    check("sense_res", result, 8'h30); check("sense_err", error, 0); check("model_sense", m_acc, 8'h30);
    run_op(3'd4, 0, 5, 0, 8'h00, 0, 0);
    run_op(3'd1, 0, 0, 0, 8'h00, 0, 0);
    check("sense0_res", result, 8'h10);
    run_op(3'd5, 0, 5, 0, 8'h00, 0, 0);
    check("rdmem_res", result, 8'h30); check("model_rdmem", m_acc, 8'h30);
    run_op(3'd6, 0, 14, 0, 8'h00, 0, 0);
    check("scan_res", result, 8'h40); check("model_scan1", m_mem[1], 8'h40);
    run_op(3'd5, 0, 0, 0, 8'h00, 0, 0);
    check("scan_wrap0", result, 8'h30);
    run_op(3'd5, 0, 15, 0, 8'h00, 0, 0);
    check("scan_15", result, 8'h20);
    run_op(3'd2, 0, 0, 2, 8'hAA, 0, 0);
    check("rx_aa", result, 8'hAA);
    run_op(3'd3, 0, 0, 5, 8'h00, 0, 0);
    check("tx_ok_err", error, 0); check("tx_ok_res", result, 8'hAA);
    run_op(3'd3, 0, 0, RTO + 10, 8'h00, 0, 0);
    check("tx_to_err", error, 1); check("tx_to_txv", tx_valid, 0);
    run_op(3'd3, 0, 0, RTO, 8'h00, 0, 0);
    check("tx_last_err", error, 0);
    run_op(3'd2, 0, 0, RTO + 3, 8'h00, 0, 0);
    check("rx_to_err", error, 1); check("rx_to_res", result, 8'hAA);
    run_op(3'd2, 0, 0, 3, 8'h55, 0, 0);
    check("rx_55", result, 8'h55); check("rx_55_err", error, 0);
    run_op(3'd7, 0, 0, 0, 8'h00, 0, 0);
    check("ill_err", error, 1); check("ill_res", result, 8'h55);
    run_op(3'd0, 0, 0, 0, 8'h00, 0, 0);
    check("nop_busy", busy, 0);

    enable = 0; inst_valid = 1; inst = 3'd1;
    repeat (5) step();
    check("en0_busy", busy, 0); check("en0_ready", inst_ready, 0);
    inst_valid = 0; enable = 1;
    run_op(3'd1, 1, 0, 0, 8'h00, 0, 1);
    check("en_drop_res", result, 8'h20);

    // Reset three cycles into a stalled WRITE_RADIO
    while (!inst_ready) step();
    inst_valid = 1; inst = 3'd3;
    t = cyc + 1;
    cur_v = 1; cur_t = t; cur_done = t + RTO + 1; cur_txend = t + RTO;
    cur_txd = m_acc; cur_res = m_acc; cur_err = 1;
    step();
    inst_valid = 0;
    step(); step();
    rst = 1; cur_v = 0; m_acc = 0; m_last_res = 0;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    step();
    check("rst_mid_txv", tx_valid, 0); check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);    check("rst_mid_res", result, 0);
    step();
    rst = 0;
    repeat (3) step();

    for (int i = 0; i < 90; i++) begin
      int op, ch, a, d;
      op = $urandom_range(0, 7); ch = $urandom_range(0, NCH - 1); a = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 7))
        0:       d = RTO;
        1:       d = RTO + 1 + $urandom_range(0, 4);
        default: d = $urandom_range(1, 10);
      endcase
      if (op == 5 && !m_wr[a]) op = 4;
      sensor_in = $urandom;
      run_op(3'(op), ch, a, d, DW'($urandom), 1, (i % 9 == 4));
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
